// File: rtl/ghost_chaser.sv
// Ghost movement controller: waits for Pacman's start, leaves the pen, then chases
// Pacman tile by tile and latches a sticky catch flag on overlap.
module ghost_chaser #(
   parameter logic [9:0] START_X     = 10'h0A8,
   parameter logic [9:0] START_Y     = 10'h088,
   parameter int         EXIT_PIXELS = 16,
   parameter int         MOVE_DIV    = 1,
   parameter int         CATCH_DIST  = 8
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       ggShow,
   input  logic [9:0] pac_x,
   input  logic [9:0] pac_y,
   input  logic [3:0] wall_open,
   output logic [9:0] ghost_x,
   output logic [9:0] ghost_y,
   output logic [3:0] ghost_dir,
   output logic       caught
);

   localparam int DIV_W  = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
   localparam int EXIT_W = $clog2(EXIT_PIXELS + 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(MOVE_DIV - 1);
   localparam logic [EXIT_W-1:0] EXIT_LAST = EXIT_W'(EXIT_PIXELS - 1);
   localparam logic [9:0]        CATCH_LIM = 10'(CATCH_DIST);

   localparam logic [3:0] DIR_UP    = 4'b1000;
   localparam logic [3:0] DIR_DOWN  = 4'b0100;
   localparam logic [3:0] DIR_LEFT  = 4'b0010;
   localparam logic [3:0] DIR_RIGHT = 4'b0001;

   typedef enum logic [1:0] {ST_IDLE, ST_EXIT, ST_CHASE, ST_CAUGHT} state_t;

   state_t              state_r, state_s;
   logic [9:0]          ghost_x_r, ghost_x_s;
   logic [9:0]          ghost_y_r, ghost_y_s;
   logic [3:0]          ghost_dir_r, ghost_dir_s;
   logic                caught_r, caught_s;
   logic [EXIT_W-1:0]   exit_cnt_r, exit_cnt_s;
   logic [DIV_W-1:0]    div_cnt_r, div_cnt_s;

   logic                freeze_s, move_en_s, crossing_s, catch_s;
   logic [3:0]          rev_dir_s, cand_s, choice_s;
   logic [10:0]         dist_up_s, dist_down_s, dist_left_s, dist_right_s, best_dist_s;
   logic                found_s;
   logic [19:0]         step_s;

   function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
      if (a >= b) begin
         return a - b;
      end else begin
         return b - a;
      end
   endfunction

   function automatic logic [10:0] manhattan(input logic [9:0] ax, input logic [9:0] ay,
                                             input logic [9:0] bx, input logic [9:0] by);
      return {1'b0, abs_diff(ax, bx)} + {1'b0, abs_diff(ay, by)};
   endfunction

   // One pixel step in a one-hot direction; returns {x, y}, unchanged for no direction.
   function automatic logic [19:0] step_pos(input logic [3:0] dir, input logic [9:0] x,
                                            input logic [9:0] y);
      case (dir)
         DIR_UP:    return {x, y - 10'd1};
         DIR_DOWN:  return {x, y + 10'd1};
         DIR_LEFT:  return {x - 10'd1, y};
         DIR_RIGHT: return {x + 10'd1, y};
         default:   return {x, y};
      endcase
   endfunction

   // Direction choice at a tile crossing: closest open non-reverse neighbour, up>left>down>right on ties.
   always_comb begin
      rev_dir_s    = {ghost_dir_r[2], ghost_dir_r[3], ghost_dir_r[0], ghost_dir_r[1]};
      cand_s       = wall_open & ~rev_dir_s;
      dist_up_s    = manhattan(ghost_x_r, ghost_y_r - 10'd16, pac_x, pac_y);
      dist_down_s  = manhattan(ghost_x_r, ghost_y_r + 10'd16, pac_x, pac_y);
      dist_left_s  = manhattan(ghost_x_r - 10'd16, ghost_y_r, pac_x, pac_y);
      dist_right_s = manhattan(ghost_x_r + 10'd16, ghost_y_r, pac_x, pac_y);
      found_s      = 1'b0;
      best_dist_s  = 11'd0;
      choice_s     = 4'b0000;
      if (cand_s[3]) begin
         found_s = 1'b1; best_dist_s = dist_up_s; choice_s = DIR_UP;
      end else begin
         found_s = found_s;
      end
      if (cand_s[1] && (!found_s || dist_left_s < best_dist_s)) begin
         found_s = 1'b1; best_dist_s = dist_left_s; choice_s = DIR_LEFT;
      end else begin
         found_s = found_s;
      end
      if (cand_s[2] && (!found_s || dist_down_s < best_dist_s)) begin
         found_s = 1'b1; best_dist_s = dist_down_s; choice_s = DIR_DOWN;
      end else begin
         found_s = found_s;
      end
      if (cand_s[0] && (!found_s || dist_right_s < best_dist_s)) begin
         found_s = 1'b1; best_dist_s = dist_right_s; choice_s = DIR_RIGHT;
      end else begin
         found_s = found_s;
      end
      if (!found_s && ((wall_open & rev_dir_s) != 4'b0000)) begin
         choice_s = rev_dir_s;
      end else begin
         choice_s = choice_s;
      end
   end

   // Next-state, movement and catch logic.
   always_comb begin
      state_s     = state_r;
      ghost_x_s   = ghost_x_r;
      ghost_y_s   = ghost_y_r;
      ghost_dir_s = ghost_dir_r;
      caught_s    = caught_r;
      exit_cnt_s  = exit_cnt_r;
      div_cnt_s   = div_cnt_r;
      step_s      = {ghost_x_r, ghost_y_r};

      freeze_s   = ggShow || (state_r == ST_CAUGHT);
      move_en_s  = frame_tick && !freeze_s && (div_cnt_r == DIV_LAST);
      crossing_s = (ghost_x_r[3:0] == 4'd8) && (ghost_y_r[3:0] == 4'd8);
      catch_s    = (abs_diff(ghost_x_r, pac_x) < CATCH_LIM) &&
                   (abs_diff(ghost_y_r, pac_y) < CATCH_LIM);

      if (frame_tick && !freeze_s) begin
         div_cnt_s = (div_cnt_r == DIV_LAST) ? {DIV_W{1'b0}} : div_cnt_r + DIV_W'(1);
      end else begin
         div_cnt_s = div_cnt_r;
      end

      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = ST_EXIT;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_EXIT: begin
            if (move_en_s) begin
               ghost_y_s  = ghost_y_r - 10'd1;
               exit_cnt_s = exit_cnt_r + EXIT_W'(1);
               state_s    = (exit_cnt_r == EXIT_LAST) ? ST_CHASE : ST_EXIT;
            end else begin
               state_s = ST_EXIT;
            end
         end
         ST_CHASE: begin
            // A catch pre-empts any move in the same cycle, even while frozen.
            if (catch_s) begin
               caught_s = 1'b1;
               state_s  = ST_CAUGHT;
            end else if (move_en_s) begin
               if (crossing_s) begin
                  ghost_dir_s = (choice_s != 4'b0000) ? choice_s : ghost_dir_r;
                  step_s      = step_pos(choice_s, ghost_x_r, ghost_y_r);
               end else begin
                  step_s      = step_pos(ghost_dir_r, ghost_x_r, ghost_y_r);
               end
               ghost_x_s = step_s[19:10];
               ghost_y_s = step_s[9:0];
            end else begin
               state_s = ST_CHASE;
            end
         end
         ST_CAUGHT: begin
            state_s = ST_CAUGHT;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r     <= ST_IDLE;
         ghost_x_r   <= START_X;
         ghost_y_r   <= START_Y;
         ghost_dir_r <= DIR_UP;
         caught_r    <= 1'b0;
         exit_cnt_r  <= {EXIT_W{1'b0}};
         div_cnt_r   <= {DIV_W{1'b0}};
      end else begin
         state_r     <= state_s;
         ghost_x_r   <= ghost_x_s;
         ghost_y_r   <= ghost_y_s;
         ghost_dir_r <= ghost_dir_s;
         caught_r    <= caught_s;
         exit_cnt_r  <= exit_cnt_s;
         div_cnt_r   <= div_cnt_s;
      end
   end

   assign ghost_x   = ghost_x_r;
   assign ghost_y   = ghost_y_r;
   assign ghost_dir = ghost_dir_r;
   assign caught    = caught_r;

endmodule

// File: doc/ghost_chaser.md
Name: ghost_chaser

Overview:
- Ghost movement controller; the consumer end of the Pacman position/direction/start interface.
- Waits for Pacman's start flag, then exits the ghost pen.
- Chases Pacman along the maze grid, choosing a direction at each tile crossing from the wall-open flags and Pacman's position.
- Outputs ghost position/direction to sprite drawing and raises caught when it overlaps Pacman.

Parameters:
- START_X, 10'h0A8, ghost X at reset (low nibble must be 8).
- START_Y, 10'h088, ghost Y at reset (low nibble must be 8).
- EXIT_PIXELS, 16, pixels moved straight up in EXIT, walls ignored.
- MOVE_DIV, 1, ghost moves on every MOVE_DIV-th frame_tick (1 = every tick).
- CATCH_DIST, 8, overlap threshold in pixels per axis.

Ports:
- Clk  input  1  system clock (50 MHz)
- Reset  input  1  synchronous, active-high reset
- frame_tick  input  1  one-Clk-wide pulse per video frame, synchronous to Clk
- start  input  1  Pacman has started moving (level, stays high)
- ggShow  input  1  game over; freezes the ghost
- pac_x  input  10  Pacman X pixel
- pac_y  input  10  Pacman Y pixel
- wall_open  input  4  open paths at the ghost's current tile, bits 3210 = up,down,left,right; combinational lookup from ghost_x/ghost_y, valid the same cycle
- ghost_x  output  10  ghost X pixel
- ghost_y  output  10  ghost Y pixel
- ghost_dir  output  4  one-hot current direction, 3210 = up,down,left,right
- caught  output  1  ghost overlaps Pacman; sticky until Reset

Behaviour:
- Clocking: one clock (Clk); reset is synchronous, active-high, on Reset. All state updates on posedge Clk. Movement only in cycles where frame_tick=1 and the move divider fires.
- Reset values:
  - ghost_x=START_X, ghost_y=START_Y
  - ghost_dir=4'b1000
  - caught=0, state=IDLE, exit counter=0, divider=0
- Move divider: counts frame_ticks 0..MOVE_DIV-1. A move is enabled on the tick where the count equals MOVE_DIV-1; the count then wraps to 0.
- Freeze: when ggShow=1 or state=CAUGHT, no position/direction change and the divider holds.
- States:
  - IDLE: hold position. On a cycle with start=1, go to EXIT.
  - EXIT: each enabled move, ghost_y -= 1 and the exit counter increments. When the counter reaches EXIT_PIXELS, go to CHASE; ghost_dir stays up.
  - CHASE: per enabled move:
    - Crossing = ghost_x[3:0]==8 and ghost_y[3:0]==8.
    - Not at a crossing: step 1 px in ghost_dir (up = y-1, down = y+1, left = x-1, right = x+1).
    - At a crossing: candidates are directions with wall_open=1, excluding the reverse of ghost_dir.
    - For each candidate, compute the Manhattan distance from the candidate point (ghost ±16 on that axis) to (pac_x,pac_y). Each axis difference is an absolute value; the sum is 11-bit unsigned with no overflow.
    - Choose the minimum distance; ties are broken by priority up > left > down > right.
    - If there is no candidate but the reverse is open, choose the reverse. If nothing is open, hold position and direction.
    - Load ghost_dir with the choice and step 1 px in it in the same move.
  - CAUGHT: terminal; only Reset exits.
- Catch detection:
  - Evaluated every Clk cycle in CHASE on registered positions.
  - Condition: |ghost_x-pac_x| < CATCH_DIST and |ghost_y-pac_y| < CATCH_DIST.
  - Next cycle: caught=1 and state=CAUGHT (1-cycle latency). This holds even if ggShow=1.
- Simultaneous events:
  - start rising on the same cycle as frame_tick: the transition to EXIT happens; the first exit move is on the next enabled tick.
  - Catch and move in the same cycle: catch wins; the position does not update.
- Reset mid-operation: returns to reset values regardless of state.
- Arithmetic: 10-bit positions wrap modulo 1024 (maze walls prevent reaching the edges).

Test Plan:
- Reset, start=0, 10 frame_ticks -> ghost_x=0x0A8, ghost_y=0x088, ghost_dir=1000, caught=0 throughout.
- start=1, then 16 frame_ticks (MOVE_DIV=1) -> ghost_y=0x078, state CHASE, ghost_x unchanged. Ticks 1-15 show y decreasing by 1 per tick.
- Ghost at (0x0A8,0x078) dir up, wall_open=1111, pac at (0x028,0x078), then tick -> ghost_dir=0010 and ghost_x=0x0A7. Down is never picked; left wins (distance 112 vs 144).
- Crossing with wall_open=0100 and dir up (only the reverse is open), tick -> ghost_dir=0100, ghost_y+1. Then wall_open=0000 at a crossing, tick -> no change.
- Tie case: pac directly diagonal so up and left are equidistant, wall_open=1011 -> up chosen.
- pac placed 5 px from the ghost on each axis in CHASE -> caught=1 exactly one Clk later. Further ticks don't move the ghost. Reset -> caught=0, position back at START.
